// File: rtl/vector_mover_pkg.sv
// Shared types and helpers for the vector memory mover.
// State encoding, beat count and lane addressing.
package vector_mover_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LCAP,
        LWB,
        SRD,
        SWR
    } mover_state_t;

    // Number of memory beats that make up one vector.
    function automatic int beats(input int bits, input int word);
        return bits / word;
    endfunction

    // Bit offset of a given lane inside the vector.
    function automatic int lane_lsb(input int lane, input int word);
        return lane * word;
    endfunction

endpackage

// File: rtl/lane_buffer.sv
// Vector staging register split into WORD-sized lanes.
// Supports whole-vector load, single-lane write and lane read.
module lane_buffer
    import vector_mover_pkg::*;
#(
    parameter int BITS = 128,
    parameter int WORD = 32,
    parameter int IW   = $clog2(BITS / WORD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [BITS-1:0] load_data,
    input  logic            lane_we,
    input  logic [IW-1:0]   lane_idx,
    input  logic [WORD-1:0] lane_data,
    input  logic [IW-1:0]   rd_idx,
    output logic [WORD-1:0] rd_data,
    output logic [BITS-1:0] q
);

    localparam int BEATS = beats(BITS, WORD);

    logic [BITS-1:0] buf_q;

    // Parallel snapshot wins over a lane write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (load_en) begin
            buf_q <= load_data;
        end else if (lane_we) begin
            for (int i = 0; i < BEATS; i++) begin
                if (lane_idx == IW'(i)) begin
                    buf_q[lane_lsb(i, WORD) +: WORD] <= lane_data;
                end
            end
        end
    end

    // Select one lane for the memory write path.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_data = buf_q[lane_lsb(i, WORD) +: WORD];
            end
        end
    end

    assign q = buf_q;

endmodule

// File: rtl/vector_mem_mover.sv
// Moves one vector between word memory and the register file.
// One command at a time; loads take BEATS+3 cycles, stores BEATS+2.
module vector_mem_mover
    import vector_mover_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int BITS   = 128,
    parameter int WORD   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_store,
    input  logic [$clog2(DEPTH)-1:0] cmd_reg,
    input  logic [ADDR_W-1:0]        cmd_addr,
    output logic                     done,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD-1:0]          mem_wdata,
    input  logic [WORD-1:0]          mem_rdata,
    output logic [$clog2(DEPTH)-1:0] rf_addressw,
    output logic [BITS-1:0]          rf_writeData,
    output logic                     rf_writeEn,
    output logic [$clog2(DEPTH)-1:0] rf_address1,
    input  logic [BITS-1:0]          rf_read1
);

    localparam int BEATS = beats(BITS, WORD);
    localparam int IW    = $clog2(BEATS);
    localparam int RW    = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    mover_state_t      state;
    logic [IW-1:0]     k;
    logic [RW-1:0]     rsel;
    logic [ADDR_W-1:0] base;

    logic              buf_load;
    logic              lane_we;
    logic [IW-1:0]     lane_idx;
    logic [WORD-1:0]   lane_rd;
    logic [BITS-1:0]   vec;
    logic [ADDR_W-1:0] beat_addr;

    // Read data lags mem_re by one cycle, so lanes fill one beat behind.
    assign buf_load = (state == SRD);
    assign lane_we  = ((state == LOAD) && (k != '0)) || (state == LCAP);
    assign lane_idx = (state == LCAP) ? k : k - 1'b1;

    lane_buffer #(
        .BITS (BITS),
        .WORD (WORD),
        .IW   (IW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (buf_load),
        .load_data (rf_read1),
        .lane_we   (lane_we),
        .lane_idx  (lane_idx),
        .lane_data (mem_rdata),
        .rd_idx    (k),
        .rd_data   (lane_rd),
        .q         (vec)
    );

    // Command sequencer with beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            rsel  <= '0;
            base  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsel  <= cmd_reg;
                        base  <= cmd_addr;
                        k     <= '0;
                        state <= cmd_store ? SRD : LOAD;
                    end
                end
                LOAD: begin
                    if (k == LAST) state <= LCAP;
                    else           k     <= k + 1'b1;
                end
                LCAP: state <= LWB;
                LWB:  state <= IDLE;
                SRD: begin
                    k     <= '0;
                    state <= SWR;
                end
                SWR: begin
                    if (k == LAST) state <= IDLE;
                    else           k     <= k + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign beat_addr = base + ADDR_W'(k);

    assign cmd_ready  = rst_n & (state == IDLE);
    assign mem_re     = rst_n & (state == LOAD);
    assign mem_we     = rst_n & (state == SWR);
    assign rf_writeEn = rst_n & (state == LWB);
    assign done       = rst_n & ((state == LWB) |
                                 ((state == SWR) & (k == LAST)));

    assign mem_addr  = (mem_re | mem_we) ? beat_addr : '0;
    assign mem_wdata = mem_we ? lane_rd : '0;

    assign rf_addressw  = rsel;
    assign rf_address1  = rsel;
    assign rf_writeData = vec;

endmodule

// File: tb/tb_vector_mem_mover.sv
// Randomized bench for vector_mem_mover with memory and
// register-file models plus a reference register image.
module tb_vector_mem_mover;

    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_store;
    logic [3:0]   cmd_reg;
    logic [31:0]  cmd_addr;
    logic         done;
    logic         mem_re;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;
    logic [3:0]   rf_addressw;
    logic [127:0] rf_writeData;
    logic         rf_writeEn;
    logic [3:0]   rf_address1;
    logic [127:0] rf_read1;

    always #5 clk = ~clk;

    vector_mem_mover dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_store    (cmd_store),
        .cmd_reg      (cmd_reg),
        .cmd_addr     (cmd_addr),
        .done         (done),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .rf_addressw  (rf_addressw),
        .rf_writeData (rf_writeData),
        .rf_writeEn   (rf_writeEn),
        .rf_address1  (rf_address1),
        .rf_read1     (rf_read1)
    );

    int tests;
    int fails;

    logic [31:0]  mem [logic [31:0]];
    logic [127:0] rf [16];
    logic [127:0] ref_rf [16];

    logic         tb_we;
    logic [3:0]   tb_waddr;
    logic [127:0] tb_wdata;
    logic         tb_mwe;
    logic [31:0]  tb_maddr;
    logic [31:0]  tb_mdata;

    logic         lg_re [32];
    logic         lg_we [32];
    logic         lg_rfwe [32];
    logic         lg_done [32];
    logic         lg_ready [32];
    logic [31:0]  lg_addr [32];
    logic [31:0]  lg_wdata [32];
    logic [3:0]   lg_rfaddr [32];
    logic [127:0] lg_rfdata [32];
    int           lg_n;
    bit           timed_out;

    // Word memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (tb_mwe) mem[tb_maddr] = tb_mdata;
    end

    // Register file: reg 0 discards writes and reads zero
    always @(posedge clk) begin
        if (rf_writeEn && rf_addressw != 4'd0) rf[rf_addressw] <= rf_writeData;
        if (tb_we && tb_waddr != 4'd0) rf[tb_waddr] <= tb_wdata;
    end

    assign rf_read1 = (rf_address1 == 4'd0) ? '0 : rf[rf_address1];

    task automatic poke_mem(input logic [31:0] a, input logic [31:0] d);
        tb_mwe = 1'b1;
        tb_maddr = a;
        tb_mdata = d;
        @(posedge clk);
        #1 tb_mwe = 1'b0;
    endtask

    task automatic poke_rf(input logic [3:0] r, input logic [127:0] d);
        tb_we = 1'b1;
        tb_waddr = r;
        tb_wdata = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Issue one command and log cycles 1..n until ready returns.
    task automatic run_cmd(input bit st, input logic [3:0] r,
                           input logic [31:0] a, input int inj_c,
                           input logic [3:0] inj_r, input logic [127:0] inj_d,
                           input int rst_c);
        int w;
        timed_out = 1'b0;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_store = st;
        cmd_reg = r;
        cmd_addr = a;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lg_n = 0;
        for (int c = 1; c < 32; c++) begin
            rst_n = !(rst_c != 0 && c >= rst_c && c <= rst_c + 1);
            tb_we = (inj_c != 0 && c == inj_c);
            tb_waddr = inj_r;
            tb_wdata = inj_d;
            @(negedge clk);
            lg_re[c] = mem_re;
            lg_we[c] = mem_we;
            lg_rfwe[c] = rf_writeEn;
            lg_done[c] = done;
            lg_ready[c] = cmd_ready;
            lg_addr[c] = mem_addr;
            lg_wdata[c] = mem_wdata;
            lg_rfaddr[c] = rf_addressw;
            lg_rfdata[c] = rf_writeData;
            lg_n = c;
            if (c >= 2 && cmd_ready) break;
            @(posedge clk);
            #1;
        end
        tb_we = 1'b0;
        rst_n = 1'b1;
        timed_out = !cmd_ready;
    endtask

    task automatic verify_load(input logic [3:0] r, input logic [31:0] a,
                               input logic [127:0] expv);
        logic [4:0] got, exp;
        run_cmd(1'b0, r, a, 0, 4'd0, '0, 0);
        tests++;
        if (timed_out || lg_n != B + 3)
            $display("FAIL load_len reg=%0d got=%0d exp=%0d", r, lg_n, B + 3);
        for (int c = 1; c <= lg_n && c <= B + 3; c++) begin
            got = {lg_re[c], lg_we[c], lg_rfwe[c], lg_done[c], lg_ready[c]};
            exp = {c <= B, 1'b0, c == B + 2, c == B + 2, c == B + 3};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL load_flags c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c <= B) begin
                tests++;
                if (lg_addr[c] !== a + 32'(c - 1)) begin
                    fails++;
                    $display("FAIL load_addr c=%0d got=%h exp=%h",
                             c, lg_addr[c], a + 32'(c - 1));
                end
            end
        end
        tests++;
        if (lg_rfaddr[B + 2] !== r || lg_rfdata[B + 2] !== expv) begin
            fails++;
            $display("FAIL load_data got=%0d:%h exp=%0d:%h",
                     lg_rfaddr[B + 2], lg_rfdata[B + 2], r, expv);
        end
        if (r != 4'd0) ref_rf[r] = expv;
    endtask

    task automatic verify_store(input logic [3:0] r, input logic [31:0] a,
                                input logic [127:0] expv, input int inj_c,
                                input logic [3:0] inj_r,
                                input logic [127:0] inj_d);
        logic [4:0] got, exp;
        logic [31:0] ew;
        run_cmd(1'b1, r, a, inj_c, inj_r, inj_d, 0);
        tests++;
        if (timed_out || lg_n != B + 2) begin
            fails++;
            $display("FAIL store_len reg=%0d got=%0d exp=%0d", r, lg_n, B + 2);
        end
        for (int c = 1; c <= lg_n && c <= B + 2; c++) begin
            got = {lg_re[c], lg_we[c], lg_rfwe[c], lg_done[c], lg_ready[c]};
            exp = {1'b0, c >= 2 && c <= B + 1, 1'b0, c == B + 1, c == B + 2};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL store_flags c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c >= 2 && c <= B + 1) begin
                ew = expv[(c - 2) * 32 +: 32];
                tests++;
                if (lg_addr[c] !== a + 32'(c - 2) || lg_wdata[c] !== ew) begin
                    fails++;
                    $display("FAIL store_beat c=%0d got=%h:%h exp=%h:%h",
                             c, lg_addr[c], lg_wdata[c], a + 32'(c - 2), ew);
                end
            end
        end
        if (inj_c != 0 && inj_r != 4'd0) ref_rf[inj_r] = inj_d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_store = 1'b1;
        cmd_reg = 4'd3;
        cmd_addr = 32'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({cmd_ready, mem_re, mem_we, rf_writeEn, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes got=%b exp=00000",
                     {cmd_ready, mem_re, mem_we, rf_writeEn, done});
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_mem got=%h:%h exp=0:0", mem_addr, mem_wdata);
        end
        tests++;
        if (rf_writeData !== '0 || rf_address1 !== 4'd0) begin
            fails++;
            $display("FAIL reset_buf got=%h:%0d exp=0:0", rf_writeData, rf_address1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({cmd_ready, mem_re, mem_we} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release got=%b exp=100", {cmd_ready, mem_re, mem_we});
        end
    endtask

    task automatic init_rf;
        logic [127:0] v;
        ref_rf[0] = '0;
        for (int r = 1; r < 16; r++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if (r == 3) v = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
            ref_rf[r] = v;
            poke_rf(4'(r), v);
        end
    endtask

    task automatic test_load;
        poke_mem(32'h100, 32'h00112233);
        poke_mem(32'h101, 32'h44556677);
        poke_mem(32'h102, 32'h8899AABB);
        poke_mem(32'h103, 32'hCCDDEEFF);
        verify_load(4'd5, 32'h100, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    endtask

    task automatic test_store;
        verify_store(4'd3, 32'h20, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                     0, 4'd0, '0);
    endtask

    task automatic test_wrap;
        poke_mem(32'hFFFFFFFE, 32'hA0A0A0A0);
        poke_mem(32'hFFFFFFFF, 32'hB1B1B1B1);
        poke_mem(32'h00000000, 32'hC2C2C2C2);
        poke_mem(32'h00000001, 32'hD3D3D3D3);
        verify_load(4'd6, 32'hFFFFFFFE, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    endtask

    task automatic test_reg0;
        poke_mem(32'h200, 32'h11111111);
        poke_mem(32'h201, 32'h22222222);
        poke_mem(32'h202, 32'h33333333);
        poke_mem(32'h203, 32'h44444444);
        verify_load(4'd0, 32'h200, 128'h44444444_33333333_22222222_11111111);
        verify_store(4'd0, 32'h40, '0, 0, 4'd0, '0);
    endtask

    task automatic test_backpressure;
        logic [127:0] expv;
        logic [3:0] got, exp;
        int w;
        for (int i = 0; i < B; i++) begin
            expv[i * 32 +: 32] = $urandom;
            poke_mem(32'h300 + 32'(i), expv[i * 32 +: 32]);
        end
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_store = 1'b0;
        cmd_reg = 4'd7;
        cmd_addr = 32'h300;
        @(posedge clk);
        #1 cmd_store = 1'b1;
        cmd_addr = 32'h380;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            got = {cmd_ready, mem_re, mem_we, done};
            exp = {c == 7 || c == 13, c <= 4, c >= 9 && c <= 12, c == 6 || c == 12};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL bp_flags c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c >= 9 && c <= 12) begin
                tests++;
                if (mem_addr !== 32'h380 + 32'(c - 9) ||
                    mem_wdata !== expv[(c - 9) * 32 +: 32]) begin
                    fails++;
                    $display("FAIL bp_beat c=%0d got=%h:%h exp=%h:%h", c,
                             mem_addr, mem_wdata, 32'h380 + 32'(c - 9),
                             expv[(c - 9) * 32 +: 32]);
                end
            end
            @(posedge clk);
            #1;
            if (c == 7) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        ref_rf[7] = expv;
    endtask

    task automatic test_coherence;
        verify_store(4'd3, 32'h30, ref_rf[3], 3, 4'd3,
                     128'h55555555_66666666_77777777_88888888);
    endtask

    task automatic test_reset_mid;
        logic [4:0] got, exp;
        for (int i = 0; i < B; i++) poke_mem(32'h500 + 32'(i), $urandom);
        run_cmd(1'b0, 4'd9, 32'h500, 0, 4'd0, '0, 3);
        tests++;
        if (timed_out || lg_n != 5) begin
            fails++;
            $display("FAIL rst_mid_len got=%0d exp=5", lg_n);
        end
        for (int c = 1; c <= lg_n && c <= 5; c++) begin
            got = {lg_re[c], lg_we[c], lg_rfwe[c], lg_done[c], lg_ready[c]};
            exp = {c <= 2, 1'b0, 1'b0, 1'b0, c == 5};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rst_mid_flags c=%0d got=%b exp=%b", c, got, exp);
            end
        end
        tests++;
        if (lg_rfdata[lg_n] !== '0) begin
            fails++;
            $display("FAIL rst_mid_buf got=%h exp=0", lg_rfdata[lg_n]);
        end
        verify_store(4'd9, 32'h600, ref_rf[9], 0, 4'd0, '0);
    endtask

    task automatic test_random;
        bit st;
        logic [3:0] r, ir;
        logic [31:0] a;
        logic [127:0] expv, d;
        bit inj;
        for (int it = 0; it < 24; it++) begin
            st = 1'($urandom_range(0, 1));
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
            else a = $urandom;
            if (!st) begin
                for (int i = 0; i < B; i++) begin
                    expv[i * 32 +: 32] = $urandom;
                    poke_mem(a + 32'(i), expv[i * 32 +: 32]);
                end
                verify_load(r, a, expv);
            end else begin
                inj = ($urandom_range(0, 2) == 0);
                ir = 4'($urandom_range(0, 15));
                d = {$urandom, $urandom, $urandom, $urandom};
                expv = (r == 4'd0) ? '0 : ref_rf[r];
                verify_store(r, a, expv, inj ? 3 : 0, ir, d);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_store = 1'b0;
        cmd_reg = '0;
        cmd_addr = '0;
        tb_we = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        tb_mwe = 1'b0;
        tb_maddr = '0;
        tb_mdata = '0;
        test_reset;
        init_rf;
        test_load;
        test_store;
        test_wrap;
        test_reg0;
        test_backpressure;
        test_coherence;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
